// File: rtl/alu_pkg.sv
// Shared types and header layout for the multi-channel ALU framer.
// Imported by the per-channel FIFO and the framer top.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA
    } state_e;

    localparam int LEN_LSB    = 0;
    localparam int CH_LSB     = 8;
    localparam int SEQ_LSB    = 16;
    localparam int SEQ_W      = 8;
    localparam int DROP_CNT_W = 16;

    function automatic logic [23:0] hdr_pack(
        input logic [7:0]       len,
        input logic [7:0]       ch,
        input logic [SEQ_W-1:0] seq
    );
        logic [23:0] h;
        h = '0;
        h[LEN_LSB +: 8]    = len;
        h[CH_LSB +: 8]     = ch;
        h[SEQ_LSB +: SEQ_W] = seq;
        return h;
    endfunction

endpackage

// File: rtl/alu_chan_fifo.sv
// Per-channel synchronous FIFO with first-word-fall-through head.
// head2 exposes the entry behind the head so the framer can register it on a pop.
module alu_chan_fifo
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [DATA_W-1:0] head2,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push_ok, pop_ok;

    assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign head  = mem_q[rd_ptr_q];
    assign head2 = mem_q[rd_ptr_q + AW'(1)];

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok && !pop_ok) cnt_d = cnt_q + CNT_W'(1);
        if (pop_ok && !push_ok) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_mc_framer.sv
// Multi-channel ALU result framer: per-channel FIFOs, round-robin arbiter,
// and a header/data frame FSM with registered valid/ready outputs.
module alu_mc_framer
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 5,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LEN_W-1:0]      frame_len,
    input  logic                  frame_len_val,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic                  alu_ready,
    input  logic [CH_W-1:0]       alu_ch,
    input  logic [DATA_W-1:0]     alu_result,
    output logic                  alu_bp,
    output logic                  frame,
    output logic [DATA_W-1:0]     frame_data,
    output logic                  frame_sof,
    output logic                  frame_eof,
    input  logic                  frame_rdy,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] head_v  [NUM_CH];
    logic [DATA_W-1:0] head2_v [NUM_CH];
    logic [CNT_W-1:0]  cnt_v   [NUM_CH];
    logic [NUM_CH-1:0] full_v, empty_v, push_v, pop_v, elig;

    logic [LEN_W-1:0]      len_q [NUM_CH];
    logic [LEN_W-1:0]      len_d [NUM_CH];
    logic [SEQ_W-1:0]      seq_q [NUM_CH];
    logic [SEQ_W-1:0]      seq_d [NUM_CH];
    state_e                state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [CH_W-1:0]       last_grant_q, last_grant_d;
    logic [LEN_W-1:0]      len_cur_q, len_cur_d;
    logic [LEN_W-1:0]      beats_q, beats_d;
    logic                  frame_q, frame_d;
    logic                  sof_q, sof_d;
    logic                  eof_q, eof_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    logic            in_range, tgt_en, drop;
    logic            gnt_found;
    logic [CH_W-1:0] gnt_ch;
    logic [LEN_W-1:0] wr_len;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        alu_chan_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push_v[g]),
            .wdata (alu_result),
            .pop   (pop_v[g]),
            .head  (head_v[g]),
            .head2 (head2_v[g]),
            .count (cnt_v[g]),
            .full  (full_v[g]),
            .empty (empty_v[g])
        );
    end

    // Channel decode by compare so tags beyond NUM_CH fall out as drops.
    always_comb begin
        alu_bp   = 1'b0;
        in_range = 1'b0;
        tgt_en   = 1'b0;
        push_v   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (alu_ch == CH_W'(c)) begin
                alu_bp    = full_v[c];
                in_range  = 1'b1;
                tgt_en    = (len_q[c] != '0);
                push_v[c] = alu_ready && !full_v[c] && (len_q[c] != '0);
            end
        end
        drop   = alu_ready && !alu_bp && !(in_range && tgt_en);
        drop_d = (drop && drop_q != '1) ? drop_q + DROP_CNT_W'(1) : drop_q;
    end

    always_comb begin
        wr_len = (32'(frame_len) > FIFO_DEPTH) ? LEN_W'(FIFO_DEPTH) : frame_len;
        len_d  = len_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (frame_len_val && cfg_ch == CH_W'(c)) len_d[c] = wr_len;
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_ch    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            elig[c] = (len_q[c] != '0) && !empty_v[c] &&
                      (32'(cnt_v[c]) >= 32'(len_q[c]));
        end
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(last_grant_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!gnt_found && elig[idx]) begin
                gnt_found = 1'b1;
                gnt_ch    = CH_W'(idx);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        last_grant_d = last_grant_q;
        len_cur_d    = len_cur_q;
        beats_d      = beats_q;
        seq_d        = seq_q;
        frame_d      = frame_q;
        sof_d        = sof_q;
        eof_d        = eof_q;
        data_d       = data_q;
        pop_v        = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    state_d   = ST_HDR;
                    ch_d      = gnt_ch;
                    len_cur_d = len_q[gnt_ch];
                    frame_d   = 1'b1;
                    sof_d     = 1'b1;
                    eof_d     = 1'b0;
                    data_d    = DATA_W'(hdr_pack(8'(len_q[gnt_ch]),
                                                 8'(gnt_ch),
                                                 seq_q[gnt_ch]));
                end
            end
            ST_HDR: begin
                if (frame_rdy) begin
                    state_d     = ST_DATA;
                    seq_d[ch_q] = seq_q[ch_q] + SEQ_W'(1);
                    sof_d       = 1'b0;
                    data_d      = head_v[ch_q];
                    eof_d       = (len_cur_q == LEN_W'(1));
                    beats_d     = len_cur_q;
                end
            end
            ST_DATA: begin
                if (frame_rdy) begin
                    pop_v[ch_q] = 1'b1;
                    if (beats_q == LEN_W'(1)) begin
                        state_d      = ST_IDLE;
                        frame_d      = 1'b0;
                        eof_d        = 1'b0;
                        data_d       = '0;
                        last_grant_d = ch_q;
                    end else begin
                        beats_d = beats_q - LEN_W'(1);
                        data_d  = head2_v[ch_q];
                        eof_d   = (beats_q == LEN_W'(2));
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
            len_cur_q    <= '0;
            beats_q      <= '0;
            len_q        <= '{default: '0};
            seq_q        <= '{default: '0};
            frame_q      <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            data_q       <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            last_grant_q <= last_grant_d;
            len_cur_q    <= len_cur_d;
            beats_q      <= beats_d;
            len_q        <= len_d;
            seq_q        <= seq_d;
            frame_q      <= frame_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            data_q       <= data_d;
            drop_q       <= drop_d;
        end
    end

    assign frame      = frame_q;
    assign frame_sof  = sof_q;
    assign frame_eof  = eof_q;
    assign frame_data = data_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_alu_mc_framer.sv
// Directed bench for alu_mc_framer with a queue-based frame model
// and a per-cycle beat/stability checker.
module tb_alu_mc_framer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  frame_len = '0;
    logic        frame_len_val = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic        alu_ready = 1'b0;
    logic [1:0]  alu_ch = '0;
    logic [31:0] alu_result = '0;
    logic        alu_bp;
    logic        frame;
    logic [31:0] frame_data;
    logic        frame_sof;
    logic        frame_eof;
    logic        frame_rdy = 1'b0;
    logic [15:0] drop_cnt;

    alu_mc_framer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_len     (frame_len),
        .frame_len_val (frame_len_val),
        .cfg_ch        (cfg_ch),
        .alu_ready     (alu_ready),
        .alu_ch        (alu_ch),
        .alu_result    (alu_result),
        .alu_bp        (alu_bp),
        .frame         (frame),
        .frame_data    (frame_data),
        .frame_sof     (frame_sof),
        .frame_eof     (frame_eof),
        .frame_rdy     (frame_rdy),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        sof;
        logic        eof;
    } beat_t;

    int          tests = 0;
    int          fails = 0;
    beat_t       exp_q[$];
    logic [31:0] mq[4][$];
    int          mlen[4];
    logic [7:0]  mseq[4];
    int          mdrop;
    logic [31:0] last_hdr[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Beat checker: every accepted beat must match the model's next beat,
    // and a stalled beat must hold all of its fields.
    logic        stall_v = 1'b0;
    logic [34:0] held;
    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                tests++;
                if ({frame, frame_sof, frame_eof, frame_data} !== held) begin
                    fails++;
                    $display("FAIL stall_hold: got %h expected %h",
                             {frame, frame_sof, frame_eof, frame_data}, held);
                end
            end
            if (frame && frame_rdy) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got %h sof %b eof %b expected none",
                             frame_data, frame_sof, frame_eof);
                end else begin
                    b = exp_q.pop_front();
                    if (frame_data !== b.d || frame_sof !== b.sof || frame_eof !== b.eof) begin
                        fails++;
                        $display("FAIL beat: got %h sof %b eof %b expected %h sof %b eof %b",
                                 frame_data, frame_sof, frame_eof, b.d, b.sof, b.eof);
                    end
                end
                if (frame_sof) last_hdr[frame_data[9:8]] = frame_data;
            end
            stall_v = frame && !frame_rdy;
            held    = {frame, frame_sof, frame_eof, frame_data};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int c = 0; c < 4; c++) begin
            mq[c].delete();
            mlen[c]     = 0;
            mseq[c]     = 8'd0;
            last_hdr[c] = '0;
        end
        mdrop = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic setlen(input int ch, input int v);
        frame_len_val = 1'b1;
        cfg_ch        = 2'(ch);
        frame_len     = 5'(v);
        step();
        frame_len_val = 1'b0;
        mlen[ch]      = (v > 8) ? 8 : v;
    endtask

    task automatic push(input int ch, input logic [31:0] d);
        alu_ready  = 1'b1;
        alu_ch     = 2'(ch);
        alu_result = d;
        step();
        alu_ready  = 1'b0;
        if (mlen[ch] == 0) mdrop++;
        else mq[ch].push_back(d);
    endtask

    task automatic expect_frame(input int ch);
        beat_t      b;
        int         n;
        logic [7:0] l8, c8;
        n   = mlen[ch];
        l8  = 8'(n);
        c8  = 8'(ch);
        b.d = {8'h00, mseq[ch], c8, l8};
        b.sof = 1'b1;
        b.eof = 1'b0;
        exp_q.push_back(b);
        for (int i = 0; i < n; i++) begin
            b.d   = mq[ch].pop_front();
            b.sof = 1'b0;
            b.eof = (i == n - 1);
            exp_q.push_back(b);
        end
        mseq[ch] = mseq[ch] + 8'd1;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 2000; k++) begin
            if (exp_q.size() == 0 && !frame) break;
            step();
        end
        if (k == 2000) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        model_clear();
        frame_rdy = 1'b0;
        #1;
        @(negedge clk);
        chk("rst_frame", 32'(frame), 32'd0);
        chk("rst_sof", 32'(frame_sof), 32'd0);
        chk("rst_eof", 32'(frame_eof), 32'd0);
        chk("rst_data", frame_data, 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_bp", 32'(alu_bp), 32'd0);
        do_reset();

        // basic frame on ch1
        frame_rdy = 1'b1;
        setlen(1, 3);
        push(1, 32'hA);
        push(1, 32'hB);
        push(1, 32'hC);
        expect_frame(1);
        drain();
        chk("basic_hdr0", last_hdr[1], 32'h0000_0103);
        push(1, 32'hD);
        push(1, 32'hE);
        push(1, 32'hF);
        expect_frame(1);
        drain();
        chk("basic_hdr1", last_hdr[1], 32'h0001_0103);

        // round robin after a ch3 blocker
        setlen(0, 2);
        setlen(2, 2);
        setlen(3, 1);
        frame_rdy = 1'b0;
        push(3, 32'h300);
        step();
        step();
        push(0, 32'h100);
        push(0, 32'h101);
        push(2, 32'h200);
        push(2, 32'h201);
        expect_frame(3);
        expect_frame(0);
        expect_frame(2);
        frame_rdy = 1'b1;
        drain();

        // round robin after a ch1 blocker: ch2 now follows ch1
        frame_rdy = 1'b0;
        setlen(1, 1);
        push(1, 32'h1F0);
        step();
        step();
        push(0, 32'h102);
        push(0, 32'h103);
        push(2, 32'h202);
        push(2, 32'h203);
        expect_frame(1);
        expect_frame(2);
        expect_frame(0);
        frame_rdy = 1'b1;
        drain();

        // backpressure and stall on ch3
        setlen(3, 8);
        frame_rdy = 1'b0;
        for (int i = 0; i < 8; i++) push(3, 32'h3000 + 32'(i));
        alu_ch = 2'd3;
        #1;
        chk("bp_full_ch3", 32'(alu_bp), 32'd1);
        alu_ch = 2'd0;
        #1;
        chk("bp_ch0", 32'(alu_bp), 32'd0);
        expect_frame(3);
        frame_rdy = 1'b1;
        step();
        alu_ch = 2'd3;
        #1;
        chk("bp_pop_cycle", 32'(alu_bp), 32'd1);
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
            frame_rdy = ~frame_rdy;
            step();
        end
        frame_rdy = 1'b1;
        drain();

        // disabled channel drops, then clamped length
        do_reset();
        for (int i = 0; i < 5; i++) push(2, 32'h2200 + 32'(i));
        chk("drop_cnt5", 32'(drop_cnt), 32'd5);
        chk("drop_model", 32'(drop_cnt), 32'(mdrop));
        chk("no_frame", 32'(frame), 32'd0);
        setlen(2, 20);
        for (int i = 0; i < 8; i++) push(2, 32'h2300 + 32'(i));
        expect_frame(2);
        drain();
        chk("clamp_hdr", last_hdr[2], 32'h0000_0208);

        // seq wrap on ch0
        do_reset();
        frame_rdy = 1'b1;
        setlen(0, 1);
        for (int i = 0; i < 257; i++) begin
            push(0, 32'h5000 + 32'(i));
            expect_frame(0);
            drain();
            if (i == 255) chk("seq_ff_hdr", last_hdr[0], 32'h00FF_0001);
        end
        chk("seq_wrap_hdr", last_hdr[0], 32'h0000_0001);

        // length change while ch0 frame is held in its header
        setlen(0, 4);
        frame_rdy = 1'b0;
        for (int i = 0; i < 4; i++) push(0, 32'h6000 + 32'(i));
        step();
        expect_frame(0);
        push(0, 32'h6004);
        setlen(0, 1);
        expect_frame(0);
        frame_rdy = 1'b1;
        drain();
        chk("midlen_hdr", last_hdr[0], 32'h0002_0001);

        // reset during a ch1 data beat
        setlen(1, 3);
        push(2, 32'h2400);
        chk("drop_pre_rst", 32'(drop_cnt), 32'(mdrop));
        frame_rdy = 1'b0;
        push(1, 32'h7000);
        push(1, 32'h7001);
        push(1, 32'h7002);
        step();
        expect_frame(1);
        frame_rdy = 1'b1;
        step();
        frame_rdy = 1'b0;
        step();
        chk("pre_rst_frame", 32'(frame), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_frame", 32'(frame), 32'd0);
        chk("rst_mid_sof", 32'(frame_sof), 32'd0);
        chk("rst_mid_eof", 32'(frame_eof), 32'd0);
        chk("rst_mid_drop", 32'(drop_cnt), 32'd0);
        model_clear();
        step();
        step();
        rst_n = 1'b1;
        step();
        frame_rdy = 1'b1;
        setlen(1, 3);
        push(1, 32'h7100);
        push(1, 32'h7101);
        push(1, 32'h7102);
        expect_frame(1);
        drain();
        chk("post_rst_hdr", last_hdr[1], 32'h0000_0103);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_mc_framer.md
# alu_mc_framer

Multi-channel successor to the single-stream ALU framer. It accepts tagged ALU results from up to NUM_CH channels, buffers each channel in its own FIFO, and emits complete frames. Each frame is one header beat followed by the channel's programmed number of data beats, sent over a valid/ready output. It sits between the ALU math stage(s) and the downstream frame consumer, and replaces the single-length, single-channel framer.

## Interface
- DATA_W, 32: result/frame data width; must be ≥ 24.
- NUM_CH, 4: channel count, 1–16; CH_W = max(1, clog2(NUM_CH)).
- FIFO_DEPTH, 8: per-channel FIFO depth; power of 2, 2–31.
- LEN_W, 5: frame length field width.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_len  in  LEN_W  data-beat count for the channel on cfg_ch; 0 disables the channel.
- frame_len_val  in  1  frame_len write strobe.
- cfg_ch  in  CH_W  channel addressed by frame_len_val.
- alu_ready  in  1  result valid.
- alu_ch  in  CH_W  channel tag of the result.
- alu_result  in  DATA_W  result data.
- alu_bp  out  1  backpressure; combinational, equals FIFO[alu_ch] full.
- frame  out  1  output beat valid.
- frame_data  out  DATA_W  header or data beat.
- frame_sof  out  1  current beat is the header.
- frame_eof  out  1  current beat is the last data beat.
- frame_rdy  in  1  downstream ready.
- drop_cnt  out  16  saturating count of results dropped on disabled channels.

## Operation
- Input transfer: alu_ready && !alu_bp.
  - Enabled channel (len ≠ 0): result is written to FIFO[alu_ch].
  - Disabled channel: result is dropped and drop_cnt increments, saturating at 0xFFFF.
  - Out-of-range alu_ch (≥ NUM_CH): result is dropped and drop_cnt increments.
- Length registers:
  - Reset value 0.
  - A write with frame_len > FIFO_DEPTH stores FIFO_DEPTH.
  - Length is sampled at grant; a write mid-frame affects the next frame only.
- Eligibility: channel c is eligible when len[c] ≠ 0 and count[c] ≥ len[c].
- FSM states IDLE, HDR, DATA:
  - IDLE: round-robin grant starting from last_grant+1. If a channel is eligible, latch ch and len → HDR. Otherwise stay in IDLE.
  - HDR: frame=1, frame_sof=1. Header layout: frame_data[7:0] = len (zero-extended), [15:8] = ch, [23:16] = seq[ch], upper bits 0. On frame_rdy: seq[ch]++ (8-bit, wraps 255→0) → DATA.
  - DATA: frame=1, frame_data = FIFO[ch] head. Each frame_rdy pops one entry and decrements the beat counter. The final beat has frame_eof=1; its transfer → IDLE and updates last_grant.
- Handshake: while frame=1 && !frame_rdy, frame, frame_data, frame_sof and frame_eof hold stable.
- Simultaneous push and pop on the same FIFO: both happen; count is unchanged.
- alu_bp uses the pre-pop count, so a full FIFO stays backpressured even in a pop cycle.
- Disabling the granted channel mid-frame does not abort the frame in progress.
- Reset (any time, including mid-frame): FIFOs empty, lengths 0, seq 0, drop_cnt 0, last_grant = NUM_CH-1, FSM IDLE.

## Timing
- Reset values: frame=0, frame_sof=0, frame_eof=0, frame_data=0, drop_cnt=0; alu_bp follows FIFO[alu_ch] full, so 0 immediately after reset.
- All outputs except alu_bp are registered.
- FIFO write at edge N; count is visible at N+1. With the FSM idle, the earliest header is valid in cycle N+2 after the push that completes the frame.
- With frame_rdy held high, a frame occupies 1+len consecutive cycles, plus one IDLE cycle before the next header.
- A frame_len_val write takes effect for eligibility in the following cycle.

## Structure
- Package alu_pkg holds:
  - FSM state enum (IDLE/HDR/DATA);
  - header field offsets (LEN_LSB=0, CH_LSB=8, SEQ_LSB=16) and SEQ_W=8;
  - DROP_CNT_W=16.
- Sub-module alu_chan_fifo (DATA_W, FIFO_DEPTH): synchronous FIFO with a first-word-fall-through head, count output, full/empty flags and the same clk/rst_n. It is instantiated NUM_CH times in a generate loop.
- Arbiter, FSM, seq counters and drop counter live in alu_mc_framer.

## Test plan
- Basic frame: len[1]=3, push A,B,C on ch1, frame_rdy=1 → header 0x000103, then A, B, C with eof on C; next ch1 header seq=1.
- Round-robin: len=2 on ch0 and ch2, both FIFOs filled simultaneously → ch0 frame first, then ch2; refill both → ch0 again (grant rotates from last).
- Backpressure/stall: FIFO_DEPTH=8 pushes on ch3 (len 8) with frame_rdy=0 → alu_bp=1 on the 9th attempt for ch3 only; toggle frame_rdy 1/0 → data held stable during low cycles, all 8 beats in order.
- Disabled/clamp: push 5 results on ch2 with len[2]=0 → drop_cnt=5, no frame; write len=20 → reads back as 8 behaviourally (frame of 8 beats).
- Wrap and mid-frame length change: 256 frames on ch0 → seq wraps 255→0; write len[0]=1 during a 4-beat frame → current frame is 4 beats, the next is 1.
- Reset mid-frame: assert rst_n low during the DATA beat of ch1 → frame/sof/eof drop immediately, drop_cnt=0; after release, new pushes give seq=0 and a fresh header.
